cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) between the two result producers, the ALU reservation station and the load/store buffer. Each cycle it picks at most one completed result and broadcasts it to the reorder buffer, reservation station and load/store buffer, which consume it without back-pressure. Losing results are held in a small per-source FIFO, and the pending state is discarded on a pipeline flush.

---
 rtl/cdb_arbiter_pkg.sv | 31 +++
 rtl/cdb_arbiter_result_fifo.sv | 61 ++++++
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 tb/tb_cdb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
// Shared definitions for the common data bus arbiter: the broadcast source
// encoding, the default ROB index width, and the grant-selection helper.
// The grant helper is used by the top level.
package cdb_arbiter_pkg;

  // Origin of a CDB broadcast.
  typedef enum logic {
    CDB_SRC_ALU = 1'b0,
    CDB_SRC_LSB = 1'b1
  } cdb_src_e;

  // ROB index width used throughout the core.
  localparam int ROBSIZE = 4;

  // Picks the winning source.
  // When both sources are eligible, the winner is the source that did not win
  // last time. When only one source is eligible, that source wins.
  // The result only matters when at least one source is eligible.
  function automatic cdb_src_e pick_winner(input logic     alu_elig,
                                           input logic     lsb_elig,
                                           input cdb_src_e last_grant);
    if (alu_elig && lsb_elig)
      return (last_grant == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
    else if (lsb_elig)
      return CDB_SRC_LSB;
    else
      return CDB_SRC_ALU;
  endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// cdb_result_fifo
// A small synchronous FIFO that holds results which lost CDB arbitration.
// Push and pop may happen in the same cycle.
// Flush empties the queue; the stored data is left untouched.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   push     : write din at the tail (caller guarantees count < DEPTH)
//   pop      : drop the head entry (caller guarantees count > 0)
//   flush    : discard all entries; takes priority over push and pop
//   din      : data to push
//   head     : oldest entry (meaningful when count > 0)
//   count    : number of valid entries, 0..DEPTH
module cdb_result_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // The storage array is not reset.
  // Entries are only read after a push has made them valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Shares the single common data bus between the ALU reservation station and
// the load/store buffer. At most one result is broadcast per cycle, and the
// CDB outputs are registered. A losing result waits in a per-source FIFO.
// An empty FIFO is bypassed, so an uncontested result appears on the CDB
// one cycle after its transfer.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   rdy                               : global enable; when low, nothing changes
//   clear                             : flush pending results (only when rdy)
//   alu_valid/alu_rob_id/alu_value    : ALU result offer
//   alu_ready                         : ALU result accepted this cycle
//   lsb_valid/lsb_rob_id/lsb_value    : load/store result offer
//   lsb_ready                         : LSB result accepted this cycle
//   cdb_valid/cdb_rob_id/cdb_value    : registered broadcast
//   cdb_src                           : 0 = ALU, 1 = LSB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_ID_W   = ROBSIZE,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                clear,
  input  logic                alu_valid,
  input  logic [ROB_ID_W-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]   alu_value,
  output logic                alu_ready,
  input  logic                lsb_valid,
  input  logic [ROB_ID_W-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]   lsb_value,
  output logic                lsb_ready,
  output logic                cdb_valid,
  output logic [ROB_ID_W-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]   cdb_value,
  output logic                cdb_src
);

  localparam int W     = ROB_ID_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [CNT_W-1:0] alu_count, lsb_count;
  logic [W-1:0]     alu_head, lsb_head;
  logic             alu_xfer, lsb_xfer;
  logic             alu_nonempty, lsb_nonempty;
  logic             alu_elig, lsb_elig;
  logic             grant_en;
  cdb_src_e         winner;
  cdb_src_e         last_grant;
  logic             alu_win, lsb_win;
  logic             alu_push, lsb_push, alu_pop, lsb_pop, flush;
  logic [W-1:0]     alu_cand, lsb_cand, win_cand;

  // Ready depends only on the occupancy count, never on the grant.
  // This keeps the path from grant to ready free of combinational logic.
  assign alu_ready = rdy && !clear && (alu_count < CNT_W'(FIFO_DEPTH));
  assign lsb_ready = rdy && !clear && (lsb_count < CNT_W'(FIFO_DEPTH));
  assign alu_xfer  = alu_valid && alu_ready;
  assign lsb_xfer  = lsb_valid && lsb_ready;

  assign alu_nonempty = (alu_count != '0);
  assign lsb_nonempty = (lsb_count != '0);
  assign alu_elig     = alu_nonempty || alu_xfer;
  assign lsb_elig     = lsb_nonempty || lsb_xfer;

  // The queued head takes precedence.
  // An empty queue lets the incoming result go straight to the bus.
  assign alu_cand = alu_nonempty ? alu_head : {alu_rob_id, alu_value};
  assign lsb_cand = lsb_nonempty ? lsb_head : {lsb_rob_id, lsb_value};

  assign grant_en = rdy && !clear && (alu_elig || lsb_elig);
  assign winner   = pick_winner(alu_elig, lsb_elig, last_grant);
  assign alu_win  = grant_en && (winner == CDB_SRC_ALU);
  assign lsb_win  = grant_en && (winner == CDB_SRC_LSB);
  assign win_cand = (winner == CDB_SRC_LSB) ? lsb_cand : alu_cand;

  // A transfer is queued unless it won while its FIFO was empty.
  // In that case it bypasses the FIFO.
  assign alu_pop  = alu_win && alu_nonempty;
  assign lsb_pop  = lsb_win && lsb_nonempty;
  assign alu_push = alu_xfer && !(alu_win && !alu_nonempty);
  assign lsb_push = lsb_xfer && !(lsb_win && !lsb_nonempty);
  assign flush    = rdy && clear;

  cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (alu_push),
    .pop   (alu_pop),
    .flush (flush),
    .din   ({alu_rob_id, alu_value}),
    .head  (alu_head),
    .count (alu_count)
  );

  cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .W(W)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .flush (flush),
    .din   ({lsb_rob_id, lsb_value}),
    .head  (lsb_head),
    .count (lsb_count)
  );

  // When no source is eligible, only cdb_valid drops.
  // The other CDB fields keep their last values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= 1'b0;
      last_grant <= CDB_SRC_LSB;
    end else if (rdy) begin
      if (clear) begin
        cdb_valid  <= 1'b0;
        last_grant <= CDB_SRC_LSB;
      end else if (grant_en) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= win_cand[W-1:DATA_W];
        cdb_value  <= win_cand[DATA_W-1:0];
        cdb_src    <= winner;
        last_grant <= winner;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter.
// Expected behaviour comes from a queue-based reference model. In each cycle
// the model appends accepted offers to per-source queues, then pops the front
// of the winning queue onto the CDB.
module tb_cdb_arbiter;

  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2;

  typedef struct packed {
    logic [ROB_ID_W-1:0] id;
    logic [DATA_W-1:0]   value;
  } item_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                rdy;
  logic                clear;
  logic                alu_valid;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [DATA_W-1:0]   alu_value;
  logic                alu_ready;
  logic                lsb_valid;
  logic [ROB_ID_W-1:0] lsb_rob_id;
  logic [DATA_W-1:0]   lsb_value;
  logic                lsb_ready;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [DATA_W-1:0]   cdb_value;
  logic                cdb_src;

  int checks   = 0;
  int failures = 0;

  item_t               alu_q[$];
  item_t               lsb_q[$];
  logic                exp_valid, exp_src, exp_last;
  logic [ROB_ID_W-1:0] exp_id;
  logic [DATA_W-1:0]   exp_value;
  logic                exp_alu_ready, exp_lsb_ready;
  logic                obs_alu_ready, obs_lsb_ready;
  logic [39:0]         obs_vec, exp_vec;

  cdb_arbiter #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .alu_valid  (alu_valid),
    .alu_rob_id (alu_rob_id),
    .alu_value  (alu_value),
    .alu_ready  (alu_ready),
    .lsb_valid  (lsb_valid),
    .lsb_rob_id (lsb_rob_id),
    .lsb_value  (lsb_value),
    .lsb_ready  (lsb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    alu_q.delete();
    lsb_q.delete();
    exp_valid = 1'b0;
    exp_src   = 1'b0;
    exp_id    = '0;
    exp_value = '0;
    exp_last  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    alu_valid = 1'b0; lsb_valid = 1'b0;
    alu_rob_id = '0; alu_value = '0; lsb_rob_id = '0; lsb_value = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one cycle of inputs and records the readys the DUT shows.
  // It also advances the reference model.
  // It returns #1 after the rising edge, so the CDB outputs can be sampled.
  task automatic drive_cycle(input logic r, input logic c,
                             input logic av, input logic [ROB_ID_W-1:0] aid,
                             input logic [DATA_W-1:0] aval,
                             input logic lv, input logic [ROB_ID_W-1:0] lid,
                             input logic [DATA_W-1:0] lval);
    item_t it;
    logic  a_el, l_el, win;
    @(negedge clk);
    rdy = r; clear = c;
    alu_valid = av; alu_rob_id = aid; alu_value = aval;
    lsb_valid = lv; lsb_rob_id = lid; lsb_value = lval;
    #1;
    obs_alu_ready = alu_ready;
    obs_lsb_ready = lsb_ready;
    exp_alu_ready = r && !c && (alu_q.size() < DEPTH);
    exp_lsb_ready = r && !c && (lsb_q.size() < DEPTH);
    if (r) begin
      if (c) begin
        alu_q.delete();
        lsb_q.delete();
        exp_valid = 1'b0;
        exp_last  = 1'b1;
      end else begin
        if (av && exp_alu_ready) begin it.id = aid; it.value = aval; alu_q.push_back(it); end
        if (lv && exp_lsb_ready) begin it.id = lid; it.value = lval; lsb_q.push_back(it); end
        a_el = (alu_q.size() > 0);
        l_el = (lsb_q.size() > 0);
        if (a_el || l_el) begin
          win = (a_el && l_el) ? !exp_last : l_el;
          it  = win ? lsb_q.pop_front() : alu_q.pop_front();
          exp_valid = 1'b1;
          exp_id    = it.id;
          exp_value = it.value;
          exp_src   = win;
          exp_last  = win;
        end else begin
          exp_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    alu_valid = 1'b0; lsb_valid = 1'b0;
    alu_rob_id = '0; alu_value = '0; lsb_rob_id = '0; lsb_value = '0;
    model_reset();
    #2;
    obs_vec = {alu_ready, lsb_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value};
    exp_vec = {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("[TB] FAIL reset_state got=%h exp=%h", obs_vec, exp_vec);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_alu();
    do_reset();
    drive_cycle(1, 0, 1, 4'd3, 32'h55, 0, 4'd0, 32'h0);
    checks++;
    if ({cdb_valid, cdb_src, cdb_rob_id, cdb_value} !== {1'b1, 1'b0, 4'd3, 32'h55}) begin
      failures++;
      $display("[TB] FAIL single_alu_bcast got=%b/%b/%h/%h exp=1/0/3/55",
               cdb_valid, cdb_src, cdb_rob_id, cdb_value);
    end
    drive_cycle(1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    checks++;
    if (cdb_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_alu_idle cdb_valid got=%b exp=0", cdb_valid);
    end
  endtask

  task automatic test_contention();
    do_reset();
    drive_cycle(1, 0, 1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2);
    for (int i = 0; i < 3; i++) begin
      obs_vec = {obs_alu_ready, obs_lsb_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value};
      exp_vec = {exp_alu_ready, exp_lsb_ready, exp_valid, exp_src, exp_id, exp_value};
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL contention cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
      drive_cycle(1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive_cycle(1, 0, i < 8, 4'(i), $urandom, i < 8, 4'(i + 8), $urandom);
      obs_vec = {obs_alu_ready, obs_lsb_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value};
      exp_vec = {exp_alu_ready, exp_lsb_ready, exp_valid, exp_src, exp_id, exp_value};
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_rdy_low();
    logic [3:0] r_pat [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(r_pat[i], 0, i < 5, 4'(i + 1), $urandom, i < 2, 4'(i + 9), $urandom);
      obs_vec = {obs_alu_ready, obs_lsb_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value};
      exp_vec = {exp_alu_ready, exp_lsb_ready, exp_valid, exp_src, exp_id, exp_value};
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL rdy_low cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1, i == 3, i < 4, 4'(i + 2), $urandom, i < 4, 4'(i + 10), $urandom);
      obs_vec = {obs_alu_ready, obs_lsb_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value};
      exp_vec = {exp_alu_ready, exp_lsb_ready, exp_valid, exp_src, exp_id, exp_value};
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL clear cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++)
      drive_cycle(1, 0, 1, 4'(i), $urandom, 1, 4'(i + 4), $urandom);
    alu_valid = 1'b0; lsb_valid = 1'b0; rdy = 1'b1; clear = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    obs_vec = {alu_ready, lsb_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value};
    exp_vec = {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0};
    checks++;
    if (obs_vec !== exp_vec) begin
      failures++;
      $display("[TB] FAIL async_reset got=%h exp=%h", obs_vec, exp_vec);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, 0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
      obs_vec = {obs_alu_ready, obs_lsb_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value};
      exp_vec = {exp_alu_ready, exp_lsb_ready, exp_valid, exp_src, exp_id, exp_value};
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL async_reset_drain cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 3) != 0, 4'($urandom), $urandom,
                  $urandom_range(0, 3) != 0, 4'($urandom), $urandom);
      obs_vec = {obs_alu_ready, obs_lsb_ready, cdb_valid, cdb_src, cdb_rob_id, cdb_value};
      exp_vec = {exp_alu_ready, exp_lsb_ready, exp_valid, exp_src, exp_id, exp_value};
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_back_to_back();
    test_rdy_low();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
